// File: rtl/pe_psum_packetizer.sv
// pe_psum_packetizer: transmit-side NoC interface for a spiking-PE core.
// Buffers 8-bit partial sums in a small FIFO and packs up to three per
// 34-bit packet headed by {dest, src, nvalid}, then hands it to the router.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   psum_valid/ready/data/last  PE word stream (valid/ready), last closes a packet
//   dest_addr                   destination adder address, sampled with each word
//   pkt_valid/ready/data        packet stream to the router P_in port
//   pkt_count                   packets sent since reset (wraps)
//   busy                        FIFO non-empty, slots occupied, or packet pending
module pe_psum_packetizer #(
    parameter int unsigned WIDTH      = 34,
    parameter int unsigned PSUM_W     = 8,
    parameter logic [3:0]  SRC_ADDR   = 4'b0010,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [PSUM_W-1:0] psum_data,
    input  logic              psum_last,
    input  logic [3:0]        dest_addr,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [WIDTH-1:0]  pkt_data,
    output logic [15:0]       pkt_count,
    output logic              busy
);

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned ENTRY_W = 1 + ADDR_W + PSUM_W;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {S_COLLECT, S_SEND} state_t;

    logic [ENTRY_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_fifo_cnt;

    state_t             r_state;
    logic [1:0]         r_slot_cnt;
    logic [PSUM_W-1:0]  r_slot0;
    logic [PSUM_W-1:0]  r_slot1;
    logic [ADDR_W-1:0]  r_dest;
    logic               r_pkt_valid;
    logic [WIDTH-1:0]   r_pkt_data;
    logic [15:0]        r_pkt_count;

    logic               w_push;
    logic               w_pop;
    logic               w_done;
    logic [ENTRY_W-1:0] w_head;
    logic               w_head_last;
    logic [ADDR_W-1:0]  w_head_dest;
    logic [PSUM_W-1:0]  w_head_data;
    logic [ADDR_W-1:0]  w_dest_sel;
    logic [PSUM_W-1:0]  w_s0;
    logic [PSUM_W-1:0]  w_s1;
    logic [PSUM_W-1:0]  w_s2;
    logic [1:0]         w_nvalid;
    logic [WIDTH-1:0]   w_pkt_next;

    // Ready comes from the registered count only: a full FIFO never bypasses.
    assign psum_ready  = (r_fifo_cnt != CNT_W'(FIFO_DEPTH));
    assign w_push      = psum_valid && psum_ready;
    assign w_pop       = (r_state == S_COLLECT) && (r_fifo_cnt != '0);

    assign w_head      = r_fifo[r_rd_ptr];
    assign w_head_last = w_head[ENTRY_W-1];
    assign w_head_dest = w_head[PSUM_W +: ADDR_W];
    assign w_head_data = w_head[PSUM_W-1:0];
    assign w_done      = w_head_last || (r_slot_cnt == 2'd2);

    // Packet assembled from stored slots plus the word being popped now.
    always_comb begin
        w_dest_sel = r_dest;
        w_s0       = r_slot0;
        w_s1       = '0;
        w_s2       = '0;
        if (r_slot_cnt == 2'd0) begin
            w_dest_sel = w_head_dest;
            w_s0       = w_head_data;
        end
        if (r_slot_cnt == 2'd1) begin
            w_s1 = w_head_data;
        end else if (r_slot_cnt == 2'd2) begin
            w_s1 = r_slot1;
            w_s2 = w_head_data;
        end
        w_nvalid   = r_slot_cnt + 2'd1;
        w_pkt_next = {w_dest_sel, SRC_ADDR, w_nvalid, w_s2, w_s1, w_s0};
    end

    // FIFO storage; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {psum_last, dest_addr, psum_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // COLLECT/SEND controller with registered packet outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_COLLECT;
            r_slot_cnt  <= '0;
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_dest      <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_data  <= '0;
            r_pkt_count <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_pop) begin
                        if (r_slot_cnt == 2'd0) r_dest <= w_head_dest;
                        if (w_done) begin
                            r_pkt_data  <= w_pkt_next;
                            r_pkt_valid <= 1'b1;
                            r_slot_cnt  <= '0;
                            r_state     <= S_SEND;
                        end else begin
                            if (r_slot_cnt == 2'd0) r_slot0 <= w_head_data;
                            else                    r_slot1 <= w_head_data;
                            r_slot_cnt <= r_slot_cnt + 2'd1;
                        end
                    end
                end
                S_SEND: begin
                    if (pkt_ready) begin
                        r_pkt_valid <= 1'b0;
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_slot0     <= '0;
                        r_slot1     <= '0;
                        r_state     <= S_COLLECT;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign pkt_data  = r_pkt_data;
    assign pkt_count = r_pkt_count;
    assign busy      = (r_fifo_cnt != '0) || (r_slot_cnt != 2'd0) || (r_state == S_SEND);

endmodule
